// File: rtl/dot_acc_i16.sv
// Signed 16-bit product accumulator producing saturated dot-product results.
// One result register with ready/valid handoff; results arriving while it is occupied are dropped.
module dot_acc_i16 #(
    parameter int abits  = 24,
    parameter int maxlen = 16
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_ena,
    input  logic [15:0]      i_res,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [abits-1:0] o_sum,
    output logic             o_sat,
    output logic [7:0]       o_cnt,
    output logic             o_drop
);

    // state | meaning
    // IDLE  | accumulator empty, count 0
    // ACCUM | at least one product held in acc
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state, state_nx;
    logic [abits-1:0] acc, acc_nx;
    logic [7:0]       cnt, cnt_nx;
    logic             sat_flag, sat_nx;

    logic [abits-1:0] prod_ext;
    logic [abits-1:0] base;
    logic [abits:0]   sum_wide;
    logic             ovf;
    logic [abits-1:0] sum_clamp;
    logic             sat_evt;
    logic [7:0]       cnt_inc;
    logic             closing;
    logic             out_busy;
    logic             load_out;
    logic             drop_evt;

    localparam logic [abits-1:0] SUM_MAX = {1'b0, {(abits-1){1'b1}}};
    localparam logic [abits-1:0] SUM_MIN = {1'b1, {(abits-1){1'b0}}};

    // Single abits+1 adder; the extra bit exposes overflow for the clamp.
    always_comb begin
        prod_ext  = {{(abits-16){i_res[15]}}, i_res};
        base      = (state == ACCUM) ? acc : '0;
        sum_wide  = {base[abits-1], base} + {prod_ext[abits-1], prod_ext};
        ovf       = sum_wide[abits] != sum_wide[abits-1];
        if (ovf) begin
            sum_clamp = sum_wide[abits] ? SUM_MIN : SUM_MAX;
        end else begin
            sum_clamp = sum_wide[abits-1:0];
        end
        sat_evt   = ((state == ACCUM) && sat_flag) || ovf;
        cnt_inc   = cnt + 8'd1;
        closing   = i_ena && (i_last || (cnt_inc == 8'(maxlen)));
        out_busy  = o_valid && !i_ready;
        load_out  = closing && !out_busy;
        drop_evt  = closing && out_busy;
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        sat_nx   = sat_flag;
        case (state)
            IDLE, ACCUM: begin
                if (closing) begin
                    state_nx = IDLE;
                    acc_nx   = '0;
                    cnt_nx   = 8'd0;
                    sat_nx   = 1'b0;
                end else if (i_ena) begin
                    state_nx = ACCUM;
                    acc_nx   = sum_clamp;
                    cnt_nx   = cnt_inc;
                    sat_nx   = sat_evt;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= 8'd0;
            sat_flag <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            sat_flag <= sat_nx;
        end
    end

    // A new result may replace the old one on the same edge it is accepted.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_sat   <= 1'b0;
            o_cnt   <= 8'd0;
            o_drop  <= 1'b0;
        end else begin
            if (load_out) begin
                o_valid <= 1'b1;
                o_sum   <= sum_clamp;
                o_sat   <= sat_evt;
                o_cnt   <= cnt_inc;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (drop_evt) begin
                o_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dot_acc_i16.sv
// Bench for dot_acc_i16: two parameterisations driven in parallel, checked every cycle
// against an arithmetic reference model, plus directed scenarios with literal results.
module tb_dot_acc_i16;

    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_ena = 1'b0;
    logic [15:0] i_res = 16'd0;
    logic        i_last = 1'b0;
    logic        i_ready = 1'b0;

    logic        a_valid, a_sat, a_drop;
    logic [23:0] a_sum;
    logic [7:0]  a_cnt;
    logic        b_valid, b_sat, b_drop;
    logic [16:0] b_sum;
    logic [7:0]  b_cnt;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    always #5 i_clk = ~i_clk;

    dot_acc_i16 dut_a (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_ena(i_ena), .i_res(i_res),
        .i_last(i_last), .i_ready(i_ready), .o_valid(a_valid), .o_sum(a_sum),
        .o_sat(a_sat), .o_cnt(a_cnt), .o_drop(a_drop)
    );

    dot_acc_i16 #(.abits(17), .maxlen(4)) dut_b (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_ena(i_ena), .i_res(i_res),
        .i_last(i_last), .i_ready(i_ready), .o_valid(b_valid), .o_sum(b_sum),
        .o_sat(b_sat), .o_cnt(b_cnt), .o_drop(b_drop)
    );

    typedef struct {
        longint acc;
        int     cnt;
        bit     sat;
        bit     ov;
        longint osum;
        bit     osat;
        int     ocnt;
        bit     drop;
    } mdl_t;

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    function automatic mdl_t step(mdl_t m, int ab, int ml, bit nrst, bit ena,
                                  bit last, bit rdy, longint p);
        mdl_t   n;
        longint hi, lo, s;
        bit     ev, fs;
        int     c;
        if (!nrst) begin
            n = '{default: 0};
            return n;
        end
        n  = m;
        hi = (longint'(1) << (ab - 1)) - 1;
        lo = -hi - 1;
        if (m.ov && rdy) n.ov = 1'b0;
        if (ena) begin
            s  = m.acc + p;
            ev = 1'b0;
            if (s > hi) begin s = hi; ev = 1'b1; end
            if (s < lo) begin s = lo; ev = 1'b1; end
            fs = (m.cnt == 0) ? ev : (m.sat | ev);
            c  = m.cnt + 1;
            if (last || c == ml) begin
                if (m.ov && !rdy) begin
                    n.drop = 1'b1;
                end else begin
                    n.ov   = 1'b1;
                    n.osum = s;
                    n.osat = fs;
                    n.ocnt = c;
                end
                n.acc = 0;
                n.cnt = 0;
                n.sat = 1'b0;
            end else begin
                n.acc = s;
                n.cnt = c;
                n.sat = fs;
            end
        end
        return n;
    endfunction

    always @(posedge i_clk) begin
        ma = step(ma, 24, 16, i_nrst, i_ena, i_last, i_ready, longint'($signed(i_res)));
        mb = step(mb, 17, 4, i_nrst, i_ena, i_last, i_ready, longint'($signed(i_res)));
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("a_valid", a_valid, ma.ov);
            chk("a_drop", a_drop, ma.drop);
            if (ma.ov) begin
                chk("a_sum", longint'($signed(a_sum)), ma.osum);
                chk("a_sat", a_sat, ma.osat);
                chk("a_cnt", a_cnt, ma.ocnt);
            end
            chk("b_valid", b_valid, mb.ov);
            chk("b_drop", b_drop, mb.drop);
            if (mb.ov) begin
                chk("b_sum", longint'($signed(b_sum)), mb.osum);
                chk("b_sat", b_sat, mb.osat);
                chk("b_cnt", b_cnt, mb.ocnt);
            end
        end
    end

    task automatic drive(input bit nrst, input bit ena, input int res, input bit last,
                         input bit rdy);
        @(negedge i_clk);
        i_nrst  = nrst;
        i_ena   = ena;
        i_res   = 16'(res);
        i_last  = last;
        i_ready = rdy;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b1, 1'b0, 0, 1'b0, rdy);
    endtask

    task automatic rst_cycle();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    function automatic int pick_res();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 3) return 32767;
        if (r < 5) return -32768;
        return int'($signed(16'($urandom)));
    endfunction

    initial begin
        rst_cycle();
        rst_cycle();
        chk_en = 1'b1;

        // basic dot product: 100 - 50 + 7
        drive(1, 1, 100, 0, 1);
        drive(1, 1, -50, 0, 1);
        drive(1, 1, 7, 1, 1);
        idle(1); #1;
        chk("basic_valid", a_valid, 1);
        chk("basic_sum", longint'($signed(a_sum)), 57);
        chk("basic_cnt", a_cnt, 3);
        chk("basic_sat", a_sat, 0);
        chk("basic_sum_b", longint'($signed(b_sum)), 57);

        // back-to-back single-element vectors
        drive(1, 1, 5, 1, 1);
        drive(1, 1, -3, 1, 1);
        #1;
        chk("b2b_first", longint'($signed(a_sum)), 5);
        chk("b2b_first_valid", a_valid, 1);
        idle(1); #1;
        chk("b2b_second", longint'($signed(a_sum)), -3);
        chk("b2b_second_valid", a_valid, 1);
        idle(1); #1;
        chk("b2b_cleared", a_valid, 0);

        // saturation at abits=17
        drive(1, 1, 32767, 0, 1);
        drive(1, 1, 32767, 0, 1);
        drive(1, 1, 32767, 1, 1);
        idle(1); #1;
        chk("sat_sum", longint'($signed(b_sum)), 65535);
        chk("sat_flag", b_sat, 1);
        chk("sat_cnt", b_cnt, 3);
        chk("nosat_sum_a", longint'($signed(a_sum)), 98301);
        chk("nosat_flag_a", a_sat, 0);

        // maxlen flush at maxlen=4; fifth product opens a new vector
        rst_cycle();
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 1);
        drive(1, 1, 1, 0, 1); #1;
        chk("flush_valid", b_valid, 1);
        chk("flush_sum", longint'($signed(b_sum)), 4);
        chk("flush_cnt", b_cnt, 4);
        drive(1, 1, 2, 1, 1);
        idle(1); #1;
        chk("flush_next_sum", longint'($signed(b_sum)), 3);
        chk("flush_next_cnt", b_cnt, 2);
        chk("flush_a_sum", longint'($signed(a_sum)), 7);
        chk("flush_a_cnt", a_cnt, 6);

        // backpressure and drop
        rst_cycle();
        drive(1, 1, 2, 1, 0);
        drive(1, 1, 9, 1, 0);
        idle(0); #1;
        chk("bp_sum", longint'($signed(a_sum)), 2);
        chk("bp_drop", a_drop, 1);
        chk("bp_valid", a_valid, 1);
        idle(1); #1;
        chk("bp_hold_valid", a_valid, 1);
        idle(1); #1;
        chk("bp_clear_valid", a_valid, 0);
        chk("bp_drop_sticky", a_drop, 1);

        // reset mid-vector, with i_ena asserted during reset
        drive(1, 1, 10, 0, 1);
        drive(1, 1, 20, 0, 1);
        drive(0, 1, 99, 1, 1);
        drive(1, 1, 1, 1, 1); #1;
        chk("rst_no_result", a_valid, 0);
        chk("rst_drop_clear", a_drop, 0);
        idle(1); #1;
        chk("rst_sum", longint'($signed(a_sum)), 1);
        chk("rst_cnt", a_cnt, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) < 7),
                  pick_res(),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 6));
        end
        idle(1);
        idle(1);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dot_acc_i16.md
DOT_ACC_I16 -- requirements
Module: dot_acc_i16

Interface
REQ-001 SHALL have parameter abits, default 24, signed accumulator and result width (legal range 17..32).
REQ-002 SHALL have parameter maxlen, default 16, maximum elements per vector (legal range 1..255).
REQ-003 SHALL have port i_clk input 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_nrst input 1: reset, synchronous, active-low.
REQ-005 SHALL have port i_ena input 1: signed 16-bit product valid this cycle (from the upstream 8x8 multiplier output stage).
REQ-006 SHALL have port i_res input 16: signed two's-complement product.
REQ-007 SHALL have port i_last input 1: qualified by i_ena; marks the final product of a vector.
REQ-008 SHALL have port i_ready input 1: downstream accepts o_sum this cycle.
REQ-009 SHALL have port o_valid output 1: o_sum/o_sat/o_cnt hold a completed vector result.
REQ-010 SHALL have port o_sum output abits: signed dot-product result.
REQ-011 SHALL have port o_sat output 1: saturation occurred at least once while accumulating this result.
REQ-012 SHALL have port o_cnt output 8: number of products in this result (1..maxlen).
REQ-013 SHALL have port o_drop output 1: sticky; a completed result was discarded because the output was still occupied.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (accumulator empty, count 0) and ACCUM (at least one product held).
REQ-015 SHALL, in IDLE with i_ena=1 and i_last=0, load acc=sext(i_res), count=1, clear sat flag, go to ACCUM.
REQ-016 SHALL, in ACCUM with i_ena=1 and i_last=0, set acc=sat(acc+sext(i_res)), count+1, and OR the saturation event into the sat flag.
REQ-017 SHALL compute the sum at abits+1 bits and clamp to [-2^(abits-1), 2^(abits-1)-1] on overflow.
REQ-018 SHALL treat a product as closing when i_ena=1 and (i_last=1 or the post-increment count equals maxlen).
REQ-019 SHALL, on a closing product, present the final value next cycle: o_valid=1, o_sum=sat(acc+product) (or sext(product) from IDLE), o_cnt=final count, o_sat=final flag.
REQ-020 SHALL, on a closing product, return to IDLE with acc=0 and count=0 on the same edge, so a product in the following cycle starts a new vector with no bubble.
REQ-021 SHALL hold i_ena=0 cycles without change to acc, count, or state.
REQ-022 SHALL keep o_valid, o_sum, o_sat, and o_cnt stable while o_valid=1 and i_ready=0.
REQ-023 SHALL clear o_valid on the edge where o_valid=1 and i_ready=1, unless a new result loads on that same edge, in which case o_valid stays 1 with the new values.
REQ-024 SHALL, when a result closes while o_valid=1 and i_ready=0, discard the new result, set o_drop=1, and keep the old output; accumulator still clears per REQ-020.
REQ-025 SHALL keep o_drop set until reset.
REQ-026 SHALL ignore i_ready when o_valid=0.
REQ-027 SHALL have a combinational path of at most one abits+1 adder plus clamp mux between registers; result latency is 1 cycle from the closing product.

Reset
REQ-028 SHALL, while i_nrst=0 at a rising edge, force state=IDLE, acc=0, count=0, sat flag=0, o_valid=0, o_sum=0, o_sat=0, o_cnt=0, o_drop=0.
REQ-029 SHALL discard a partially accumulated vector when reset is asserted mid-operation; no result is emitted for it.
REQ-030 SHALL ignore i_ena in any cycle where i_nrst=0.

Verification
REQ-031 SHALL cover a basic dot product: products 100, -50, 7 (last) with i_ready=1 -> one cycle after last, o_valid=1, o_sum=57, o_cnt=3, o_sat=0.
REQ-032 SHALL cover back-to-back vectors: single-element vectors 5(last) then -3(last) on consecutive cycles with i_ready=1 -> o_sum=5, then o_sum=-3 on the next cycle, o_valid high both cycles.
REQ-033 SHALL cover saturation: abits=17, products 32767, 32767, 32767 (last) -> o_sum=65535, o_sat=1, o_cnt=3.
REQ-034 SHALL cover the maxlen flush: maxlen=4, five products of 1 with no i_last -> first result o_sum=4, o_cnt=4; the fifth product starts a new vector.
REQ-035 SHALL cover backpressure and drop: i_ready=0, vector 2(last) then 9(last) -> o_sum stays 2, o_drop=1; i_ready=1 -> o_valid clears next cycle.
REQ-036 SHALL cover reset mid-vector: products 10, 20, then i_nrst=0 for one cycle, then 1(last) -> o_sum=1, o_cnt=1.
